// File: rtl/can_tx_arbiter.sv
// ============================================================================
//  Module   : can_tx_arbiter
//  Purpose  : Picks the next frame from NUM_Q TX FIFOs (lowest CAN ID, or
//             round-robin when CAN_TXARB_RR_EN is defined), holds it for the
//             bit-level transmitter and retries it on loss or error.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module can_tx_arbiter #(
    parameter int NUM_Q     = 4,
    parameter int ID_WIDTH  = 11,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 4
) (
    input  logic                 i_sys_clk,
    input  logic                 i_reset_n,
    input  logic [NUM_Q-1:0]     i_fifo_empty,
    input  logic [NUM_Q*128-1:0] i_fifo_r_data,
    output logic [NUM_Q-1:0]     o_fifo_r_en,
    output logic [127:0]         o_tx_frame,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ack,
    input  logic                 i_tx_done,
    input  logic                 i_tx_lost,
    input  logic                 i_tx_err,
    output logic [2:0]           o_src_idx,
    output logic                 o_sent,
    output logic                 o_drop,
    output logic                 o_busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_BACKOFF = 2'd3;

    logic [1:0]   r_state;
    logic [3:0]   r_err_cnt;
    logic [7:0]   r_gap_cnt;
    logic [127:0] r_tx_frame;
    logic [2:0]   r_src_idx;
    logic         r_sent;
    logic         r_drop;

    logic         w_any;
    logic [2:0]   w_win;
    logic [127:0] w_head;
    logic [NUM_Q-1:0] w_pop;

`ifdef CAN_TXARB_RR_EN
    logic [2:0] r_rr_ptr;
    logic [3:0] w_dist;
    logic [3:0] w_best_dist;
    logic [3:0] w_next;

    // Rank each non-empty FIFO by its distance past the round-robin pointer.
    always_comb begin
        w_any       = 1'b0;
        w_win       = '0;
        w_head      = '0;
        w_dist      = '0;
        w_best_dist = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            w_dist = 4'(q) - {1'b0, r_rr_ptr};
            if (3'(q) < r_rr_ptr) begin
                w_dist = w_dist + 4'(NUM_Q);
            end
            if (!i_fifo_empty[q] && (!w_any || (w_dist < w_best_dist))) begin
                w_any       = 1'b1;
                w_win       = 3'(q);
                w_best_dist = w_dist;
                w_head      = i_fifo_r_data[q*128 +: 128];
            end
        end
    end

    assign w_next = {1'b0, w_win} + 4'd1;

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rr_ptr <= '0;
        end else if ((r_state == S_IDLE) && w_any) begin
            r_rr_ptr <= (w_next == 4'(NUM_Q)) ? 3'd0 : w_next[2:0];
        end
    end
`else
    logic [ID_WIDTH-1:0] w_best_id;

    // Strict less-than while scanning upward lets the lowest index win ties.
    always_comb begin
        w_any     = 1'b0;
        w_win     = '0;
        w_head    = '0;
        w_best_id = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (!i_fifo_empty[q] &&
                (!w_any || (i_fifo_r_data[q*128+127 -: ID_WIDTH] < w_best_id))) begin
                w_any     = 1'b1;
                w_win     = 3'(q);
                w_best_id = i_fifo_r_data[q*128+127 -: ID_WIDTH];
                w_head    = i_fifo_r_data[q*128 +: 128];
            end
        end
    end
`endif

    // Pop strobe is held off while reset is asserted so no frame is lost then.
    always_comb begin
        w_pop = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            w_pop[q] = (r_state == S_IDLE) && w_any && i_reset_n && (w_win == 3'(q));
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_err_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_tx_frame <= '0;
            r_src_idx  <= '0;
            r_sent     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_sent <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_tx_frame <= w_head;
                        r_src_idx  <= w_win;
                        r_err_cnt  <= '0;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_tx_ack) begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_tx_done) begin
                        r_sent  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (i_tx_lost) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_BACKOFF;
                    end else if (i_tx_err) begin
                        r_err_cnt <= r_err_cnt + 4'd1;
                        if ((r_err_cnt + 4'd1) == 4'(MAX_RETRY)) begin
                            r_drop  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= S_BACKOFF;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (r_gap_cnt == 8'(RETRY_GAP - 1)) begin
                        r_state <= S_REQ;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fifo_r_en = w_pop;
    assign o_tx_frame  = r_tx_frame;
    assign o_tx_valid  = (r_state == S_REQ);
    assign o_src_idx   = r_src_idx;
    assign o_sent      = r_sent;
    assign o_drop      = r_drop;
    assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_can_tx_arbiter.sv
// ============================================================================
//  Module   : tb_can_tx_arbiter
//  Purpose  : Directed bench for can_tx_arbiter with a frame-level reference
//             model compared every cycle, plus literal spot checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_tx_arbiter;

    localparam int NQ  = 4;
    localparam int GAP = 4;
    localparam int MR  = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NQ-1:0]  fifo_empty;
    logic [511:0]   fifo_data;
    logic [NQ-1:0]  fifo_r_en;
    logic [127:0]   tx_frame;
    logic           tx_valid;
    logic           tx_ack, tx_done, tx_lost, tx_err;
    logic [2:0]     src_idx;
    logic           sent, drop, busy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    logic [127:0] fmem [NQ][16];
    int           wp [NQ] = '{default: 0};
    int           rp [NQ] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NQ; g++) begin : g_fifo
        assign fifo_empty[g]           = (wp[g] == rp[g]);
        assign fifo_data[g*128 +: 128] = fmem[g][rp[g]];
    end

    can_tx_arbiter #(.NUM_Q(NQ), .ID_WIDTH(11), .MAX_RETRY(MR), .RETRY_GAP(GAP)) dut (
        .i_sys_clk     (clk),
        .i_reset_n     (rst_n),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_r_data (fifo_data),
        .o_fifo_r_en   (fifo_r_en),
        .o_tx_frame    (tx_frame),
        .o_tx_valid    (tx_valid),
        .i_tx_ack      (tx_ack),
        .i_tx_done     (tx_done),
        .i_tx_lost     (tx_lost),
        .i_tx_err      (tx_err),
        .o_src_idx     (src_idx),
        .o_sent        (sent),
        .o_drop        (drop),
        .o_busy        (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit           m_hold = 0, m_req = 0, m_air = 0;
    int           m_cool = 0, m_errs = 0, m_src = 0, m_rr = 0, m_w;
    logic [127:0] m_frame = '0;
    bit           m_sent = 0, m_drop = 0;

    function automatic int model_winner();
        int best = -1;
`ifdef CAN_TXARB_RR_EN
        for (int k = 0; k < NQ; k++) begin
            int q = (m_rr + k) % NQ;
            if (best < 0 && wp[q] != rp[q]) best = q;
        end
`else
        for (int q = 0; q < NQ; q++) begin
            if (wp[q] != rp[q]) begin
                if (best < 0) best = q;
                else if (fmem[q][rp[q]][127:117] < fmem[best][rp[best]][127:117]) best = q;
            end
        end
`endif
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 0; m_req = 0; m_air = 0; m_cool = 0; m_errs = 0;
            m_src = 0; m_rr = 0; m_frame = '0; m_sent = 0; m_drop = 0;
        end else begin
            m_sent = 0;
            m_drop = 0;
            if (!m_hold) begin
                m_w = model_winner();
                if (m_w >= 0) begin
                    m_frame = fmem[m_w][rp[m_w]];
                    m_src   = m_w;
                    rp[m_w] <= rp[m_w] + 1;
                    m_errs  = 0;
                    m_hold  = 1;
                    m_req   = 1;
                    m_rr    = (m_w + 1) % NQ;
                end
            end else if (m_req) begin
                if (tx_ack) begin m_req = 0; m_air = 1; end
            end else if (m_air) begin
                if (tx_done) begin
                    m_sent = 1; m_hold = 0; m_air = 0;
                end else if (tx_lost) begin
                    m_air = 0; m_cool = GAP;
                end else if (tx_err) begin
                    m_errs++;
                    m_air = 0;
                    if (m_errs == MR) begin m_drop = 1; m_hold = 0; end
                    else m_cool = GAP;
                end
            end else begin
                m_cool--;
                if (m_cool == 0) m_req = 1;
            end
        end
    end

    logic [NQ-1:0] cexp;
    int            cw;
    always @(negedge clk) begin
        if (cmp_en) begin
            cexp = '0;
            if (rst_n && !m_hold) begin
                cw = model_winner();
                if (cw >= 0) cexp[cw] = 1'b1;
            end
            chk("cyc_r_en",  fifo_r_en, cexp);
            chk("cyc_valid", tx_valid,  m_req);
            chk("cyc_busy",  busy,      m_hold);
            chk("cyc_frame", tx_frame,  m_frame);
            chk("cyc_src",   src_idx,   3'(m_src));
            chk("cyc_sent",  sent,      m_sent);
            chk("cyc_drop",  drop,      m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    int seq = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int q, input logic [10:0] id, output logic [127:0] f);
        seq++;
        f = {id, 53'(q), 64'hFACE_0000_0000_0000 + 64'(seq)};
        fmem[q][wp[q]] = f;
        wp[q] = wp[q] + 1;
    endtask

    task automatic strobe(input int s);
        case (s)
            0: tx_ack  = 1'b1;
            1: tx_done = 1'b1;
            2: tx_lost = 1'b1;
            default: tx_err = 1'b1;
        endcase
        tick();
        tx_ack = 0; tx_done = 0; tx_lost = 0; tx_err = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!tx_valid && n < 50) begin tick(); n++; end
        if (!tx_valid) begin
            n_checks++; n_errors++;
            $display("FAIL wait_valid: o_tx_valid stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic send_one();
        wait_valid();
        strobe(0);
        strobe(1);
    endtask

    logic [127:0] fa, fb, fc;
    int           cnt;
    int           exp_order [5];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1; tx_ack = 0; tx_done = 0; tx_lost = 0; tx_err = 0;
        #1 rst_n = 0;
        #1 cmp_en = 1;

        // Reset held with all FIFOs empty
        repeat (20) tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_r_en", fifo_r_en, 0);
        chk("rst_frame", tx_frame, 0);
        rst_n = 1;
        repeat (20) tick();
        chk("idle_busy", busy, 0);

        // Lowest ID wins: FIFO3 (0x045) before FIFO1 (0x123)
        push(1, 11'h123, fa);
        push(3, 11'h045, fb);
        #1 chk("t2_pop", fifo_r_en, 4'b1000);
        tick();
        chk("t2_valid", tx_valid, 1);
        chk("t2_src", src_idx, 3);
        chk("t2_frame", tx_frame, fb);
        strobe(1);
        chk("t2_stray_done", sent, 0);
        chk("t2_still_req", tx_valid, 1);
        strobe(0);
        chk("t2_ack_drop_valid", tx_valid, 0);
        strobe(1);
        chk("t2_sent", sent, 1);
        chk("t2_next_pop", fifo_r_en, 4'b0010);
        tick();
        chk("t2_src1", src_idx, 1);
        chk("t2_frame1", tx_frame, fa);
        strobe(0); strobe(1);
        tick();

        // Equal IDs: lowest index first
        push(0, 11'h100, fa);
        push(2, 11'h100, fb);
        #1 chk("t3_pop", fifo_r_en, 4'b0001);
        tick();
        chk("t3_src", src_idx, 0);
        strobe(0); strobe(1);
        tick();
        chk("t3_src2", src_idx, 2);
        chk("t3_frame2", tx_frame, fb);
        strobe(0); strobe(1);
        tick();

        // Arbitration loss: backoff of RETRY_GAP cycles, same frame, no pop
        push(0, 11'h200, fa);
        wait_valid();
        strobe(0);
        push(1, 11'h001, fc);
        strobe(2);
        cnt = 0;
        while (!tx_valid && cnt < 50) begin tick(); cnt++; end
        chk("t4_gap", cnt, GAP);
        chk("t4_frame", tx_frame, fa);
        chk("t4_src", src_idx, 0);
        strobe(0); strobe(1);
        chk("t4_next_pop", fifo_r_en, 4'b0010);
        send_one();
        tick();

        // Three errors drop the frame; next FIFO arbitrated right away
        push(2, 11'h300, fa);
        push(3, 11'h301, fb);
        for (int i = 0; i < MR; i++) begin
            wait_valid();
            strobe(0);
            strobe(3);
            if (i < MR - 1) chk("t5_no_drop_yet", {drop, busy}, 2'b01);
        end
        chk("t5_drop", drop, 1);
        chk("t5_idle", busy, 0);
        chk("t5_next_pop", fifo_r_en, 4'b1000);
        // Fresh frame gets its own error budget
        for (int i = 0; i < MR - 1; i++) begin
            wait_valid();
            strobe(0);
            strobe(3);
        end
        chk("t5_budget_reset", busy, 1);
        wait_valid();
        chk("t5_src3", src_idx, 3);
        strobe(0);
        tx_done = 1; tx_err = 1;
        tick();
        tx_done = 0; tx_err = 0;
        chk("t5_done_wins", {sent, drop}, 2'b10);
        tick();

        // Reset during BUSY clears everything immediately
        push(0, 11'h010, fa);
        wait_valid();
        strobe(0);
        rst_n = 0;
        #1;
        chk("t6_rst_outputs", {fifo_r_en, tx_valid, busy, src_idx, sent, drop}, 0);
        chk("t6_rst_frame", tx_frame, 0);
        repeat (3) tick();
        rst_n = 1;
        tick();

        // Pop order with all four FIFOs loaded
`ifdef CAN_TXARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{3, 2, 1, 0, 0};
`endif
        push(0, 11'h700, fa);
        push(1, 11'h600, fa);
        push(2, 11'h500, fa);
        push(3, 11'h400, fa);
        push(0, 11'h050, fa);
        for (int i = 0; i < 5; i++) begin
            wait_valid();
            chk("t6_order", src_idx, 3'(exp_order[i]));
            strobe(0);
            strobe(1);
        end
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
